// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, hazard/branch controls and IF/ID outputs.
interface fetch_stage_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  ifid_pc_plus;
  logic               ifid_valid;
  logic               halted;
  logic [15:0]        fetch_count;

  // Fetch-stage side.
  modport master (
    output imem_addr, ifid_instr, ifid_pc_plus, ifid_valid, halted, fetch_count,
    input  imem_rdata, stall, redirect_valid, redirect_pc
  );

  // Memory / downstream side.
  modport slave (
    input  imem_addr, ifid_instr, ifid_pc_plus, ifid_valid, halted, fetch_count,
    output imem_rdata, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fills the IF/ID register, honours stall and
// branch redirect, and stops for good once a HALT opcode has been fetched.
module fetch_stage #(
  parameter int unsigned         ADDR_W    = 16,
  parameter int unsigned         INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC  = 16'h0000,
  parameter logic [ADDR_W-1:0]   PC_INC    = 16'd2,
  parameter logic [3:0]          HALT_OP   = 4'hF,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic [0:0] {StFetch, StHalt} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_plus_q, pc_plus_d;
  logic               valid_q, valid_d;
  logic [15:0]        count_q, count_d;

  logic [ADDR_W-1:0]  pc_inc;
  logic               is_halt_op;

  assign pc_inc     = pc_q + PC_INC;
  assign is_halt_op = (bus.imem_rdata[INSTR_W-1 -: 4] == HALT_OP);

  // Next-state logic: redirect beats stall; HALT only drains IF/ID to bubbles.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_plus_d = pc_plus_q;
    valid_d   = valid_q;
    count_d   = count_q;
    unique case (state_q)
      StFetch: begin
        if (bus.redirect_valid) begin
          // Instructions are 2-byte aligned, so the target's bit 0 is dropped.
          pc_d    = bus.redirect_pc & ~{{(ADDR_W-1){1'b0}}, 1'b1};
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          instr_d   = bus.imem_rdata;
          pc_plus_d = pc_inc;
          valid_d   = 1'b1;
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
          if (is_halt_op) begin
            state_d = StHalt;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      StHalt: begin
        if (!bus.stall) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pc_plus_q <= '0;
      valid_q   <= 1'b0;
      count_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_plus_q <= pc_plus_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.ifid_instr   = instr_q;
  assign bus.ifid_pc_plus = pc_plus_q;
  assign bus.ifid_valid   = valid_q;
  assign bus.halted       = (state_q == StHalt);
  assign bus.fetch_count  = count_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the CPU, instantiated inside top_level. It feeds the decode stage.
- Owns the program counter and drives the instruction-memory address.
- Captures the returned instruction into the IF/ID pipeline register.
- Honours stall and branch-redirect requests from the hazard/branch logic downstream.
- Stops fetching permanently when a HALT opcode is fetched.

Parameters:
ADDR_W, 16, PC and memory address width in bits (byte addressed)
INSTR_W, 16, instruction width in bits
RESET_PC, 16'h0000, PC value loaded on reset
PC_INC, 2, PC increment per sequential fetch
HALT_OP, 4'hF, opcode value (instr[INSTR_W-1 -: 4]) that halts fetch
NOP_INSTR, 16'h0000, encoding loaded into IF/ID on bubble or flush

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active low (rst==0 at a posedge resets the block)
imem_addr  out  ADDR_W  instruction memory address; combinational copy of the PC register
imem_rdata  in  INSTR_W  instruction at imem_addr; combinational read, valid in the same cycle
stall  in  1  hold the PC and IF/ID contents
redirect_valid  in  1  branch/jump taken; flush IF/ID and load redirect_pc
redirect_pc  in  ADDR_W  redirect target
ifid_instr  out  INSTR_W  registered instruction to decode
ifid_pc_plus  out  ADDR_W  registered PC+PC_INC of ifid_instr
ifid_valid  out  1  ifid_instr is a real instruction (0 = bubble)
halted  out  1  high while the FSM is in HALT
fetch_count  out  16  count of instructions loaded as valid; saturates at 16'hFFFF

Behaviour:
Reset (rst==0 at posedge):
- pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus=0, ifid_valid=0, fetch_count=0, state=FETCH.
- Hence halted=0 and imem_addr=RESET_PC.
- Reset overrides every other input in the same cycle, including mid-stall and while in HALT.

States: FETCH, HALT. halted = (state==HALT), decoded directly from the state register.

FETCH, evaluated each posedge in this priority order:
1. redirect_valid=1 (stall is ignored):
   - pc <= {redirect_pc[ADDR_W-1:1],1'b0}; bit 0 is forced to 0.
   - ifid_instr <= NOP_INSTR, ifid_valid <= 0.
   - fetch_count unchanged; state stays FETCH, even if imem_rdata holds HALT_OP (wrong-path instruction).
2. stall=1: pc, IF/ID registers and fetch_count all hold.
3. Otherwise:
   - ifid_instr <= imem_rdata, ifid_pc_plus <= pc+PC_INC (modulo 2^ADDR_W), ifid_valid <= 1.
   - fetch_count <= fetch_count+1, saturating at 16'hFFFF.
   - If imem_rdata[INSTR_W-1 -: 4]==HALT_OP: state <= HALT and pc holds (no increment). The HALT instruction itself goes downstream as valid.
   - Else pc <= pc+PC_INC; wraps, so 16'hFFFE -> 16'h0000.

HALT:
- pc frozen; redirect_valid ignored; fetch_count frozen.
- stall=1: IF/ID holds.
- stall=0: ifid_instr <= NOP_INSTR, ifid_valid <= 0.
- Exit only via reset.

Timing and outputs:
- Latency: an instruction at address A appears on ifid_instr at the posedge that samples pc==A with no stall or redirect, i.e. one cycle.
- No combinational path from stall, redirect_valid or imem_rdata to any output.
- imem_addr depends only on the pc register.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with stall=1, redirect_valid=1 -> imem_addr=0x0000, ifid_valid=0, ifid_instr=0x0000, halted=0, fetch_count=0.
2. Sequential fetch: memory 0x0000:0x1111, 0x0002:0x2222, 0x0004:0x3333; release rst -> over 3 cycles ifid_instr = 0x1111/0x2222/0x3333, ifid_pc_plus = 0x0002/0x0004/0x0006, fetch_count=3.
3. Stall: assert stall for 2 cycles while pc=0x0004 -> imem_addr stays 0x0004, ifid_instr holds 0x2222; after release, 0x3333 is loaded.
4. Redirect with stall: stall=1, redirect_valid=1, redirect_pc=0x0041 in the same cycle -> next cycle imem_addr=0x0040, ifid_valid=0; the following cycle loads mem[0x0040] with ifid_pc_plus=0x0042.
5. Halt: mem[0x0006]=0xF000 -> ifid_instr=0xF000 with ifid_valid=1, halted=1, imem_addr frozen at 0x0006. Next cycle ifid_valid=0. A later redirect to 0x0000 is ignored. rst=0 then restarts at 0x0000.
6. Wrap and wrong-path halt:
   - Redirect to 0xFFFE, mem[0xFFFE]=0x1234 -> ifid_pc_plus=0x0000 and next imem_addr=0x0000.
   - Separately, redirect_valid=1 while imem_rdata=0xF000 -> halted stays 0.
